// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the programmable clock divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/load_counter.sv
// rtl/load_counter.sv - loadable up-counter with terminal-count flag
module load_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over increment so a tick cycle reloads instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = &count_q;

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - divide-by-N tick/square-wave generator with divisor handshake
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 113
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             tick,
    output logic             div_out,
    output logic [WIDTH-1:0] cur_div,
    output logic             busy
);

    state_t           state_q;
    logic [WIDTH-1:0] cur_div_q;
    logic [WIDTH-1:0] pend_div_q;
    logic             pending_q;
    logic             div_out_q;
    logic             cfg_err_q;

    logic             tc;
    logic             tick_w;
    logic             xfer;
    logic             legal;
    logic [WIDTH-1:0] reload_div;
    logic             ctr_load;
    logic [WIDTH-1:0] ctr_load_val;

    assign tick_w     = (state_q == RUN) && tc;
    assign xfer       = cfg_valid && !pending_q;
    assign legal      = cfg_div >= WIDTH'(MIN_DIV);
    assign reload_div = pending_q ? pend_div_q : cur_div_q;

    // Counting up from 2^WIDTH-N to all-ones gives exactly N RUN cycles per tick.
    assign ctr_load     = (state_q == LOAD) || tick_w;
    assign ctr_load_val = (state_q == LOAD) ? (WIDTH'(0) - cur_div_q)
                                            : (WIDTH'(0) - reload_div);

    load_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ctr_load),
        .load_val_i (ctr_load_val),
        .inc_i      (state_q == RUN),
        .tc_o       (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_div_q  <= WIDTH'(DEFAULT_DIV);
            pend_div_q <= '0;
            pending_q  <= 1'b0;
            div_out_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= xfer && !legal;
            case (state_q)
                IDLE: begin
                    // A divisor left pending by a stop is committed here.
                    if (pending_q) begin
                        cur_div_q <= pend_div_q;
                        pending_q <= 1'b0;
                    end else if (xfer && legal) begin
                        cur_div_q <= cfg_div;
                    end
                    div_out_q <= 1'b0;
                    if (enable) begin
                        state_q <= LOAD;
                    end
                end
                LOAD, RUN: begin
                    if (tick_w) begin
                        div_out_q <= !div_out_q;
                        if (pending_q) begin
                            cur_div_q <= pend_div_q;
                            pending_q <= 1'b0;
                        end
                    end
                    if (xfer && legal) begin
                        pending_q  <= 1'b1;
                        pend_div_q <= cfg_div;
                    end
                    if (!enable) begin
                        state_q   <= IDLE;
                        div_out_q <= 1'b0;
                    end else begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_ready = !pending_q;
    assign cfg_err   = cfg_err_q;
    assign tick      = tick_w;
    assign div_out   = div_out_q;
    assign cur_div   = cur_div_q;
    assign busy      = (state_q != IDLE);

endmodule
